// File: rtl/taxi_pkg.sv
// Shared taxi definitions: pricing-state encodings, BCD digit constants and
// the two-digit BCD trip counter type, used by the state controller and the price meter.
package taxi_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MOVE = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b11;

  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_START,
    EV_PAUSE,
    EV_END
  } taxi_event_e;

  // Two-digit BCD increment; 99 rolls over to 00.
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.units == BCD_NINE) begin
      r.units = BCD_ZERO;
      r.tens  = (v.tens == BCD_NINE) ? BCD_ZERO : v.tens + 4'd1;
    end else begin
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchroniser, consecutive-cycle debouncer,
// and a single-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pressed
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;

  // Any cycle that agrees with the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      level_d <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      level_d <= level_q;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q2;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pressed = level_q & ~level_d;

endmodule

// File: rtl/taxi_state_ctrl.sv
// Taxi trip state controller: turns debounced start/pause/end presses into the
// IDLE/MOVE/WAIT pricing state, with a wait timeout, post-trip start lockout and BCD trip count.
module taxi_state_ctrl
  import taxi_pkg::*;
#(
  parameter int DEB_CYCLES  = 2,
  parameter int HOLD_CYCLES = 20,
  parameter int MAX_WAIT    = 18000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_end,
  output logic [1:0] state,
  output logic       busy,
  output logic       end_pulse,
  output logic [7:0] trip_bcd
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  logic start_ev;
  logic pause_ev;
  logic end_ev;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_start),
    .pressed (start_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_pause),
    .pressed (pause_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_end (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_end),
    .pressed (end_ev)
  );

  logic [1:0]    state_q;
  logic [1:0]    state_n;
  logic          busy_q;
  logic          end_q;
  logic          end_n;
  bcd2_t         trip_q;
  bcd2_t         trip_n;
  logic [WW-1:0] wait_q;
  logic [WW-1:0] wait_n;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_n;
  taxi_event_e   ev;
  logic          timeout;

  // Only the highest-priority press of a cycle survives.
  always_comb begin
    ev = EV_NONE;
    if (end_ev)        ev = EV_END;
    else if (pause_ev) ev = EV_PAUSE;
    else if (start_ev) ev = EV_START;
  end

  assign timeout = (state_q == ST_WAIT) && (wait_q == WAIT_LAST);

  always_comb begin
    state_n = state_q;
    end_n   = 1'b0;
    trip_n  = trip_q;
    wait_n  = wait_q;
    hold_n  = hold_q;
    if (hold_q != '0) hold_n = hold_q - 1'b1;

    case (state_q)
      ST_IDLE: if (ev == EV_START && hold_q == '0) state_n = ST_MOVE;
      ST_MOVE: begin
        if (ev == EV_PAUSE) begin
          state_n = ST_WAIT;
          wait_n  = '0;
        end
      end
      ST_WAIT: begin
        if (ev == EV_PAUSE || ev == EV_START) state_n = ST_MOVE;
        else                                  wait_n  = wait_q + 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    // A wait timeout behaves exactly like an end press when nothing else happened.
    if (state_q != ST_IDLE && (ev == EV_END || (timeout && ev == EV_NONE))) begin
      state_n = ST_IDLE;
      end_n   = 1'b1;
      trip_n  = bcd2_inc(trip_q);
      hold_n  = HOLD_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      trip_q  <= '0;
      wait_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_n;
      busy_q  <= (state_n != ST_IDLE);
      end_q   <= end_n;
      trip_q  <= trip_n;
      wait_q  <= wait_n;
      hold_q  <= hold_n;
    end
  end

  assign state     = state_q;
  assign busy      = busy_q;
  assign end_pulse = end_q;
  assign trip_bcd  = trip_q;

endmodule

// File: tb/tb_taxi_state_ctrl.sv
// Bench for taxi_state_ctrl: a reference model of button timing and trip rules checked every
// cycle, a vector table of press sequences, hand-written corner sequences and random presses.
module tb_taxi_state_ctrl;

  localparam int DEB  = 2;
  localparam int HOLD = 20;
  localparam int MAXW = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start;
  logic       btn_pause;
  logic       btn_end;
  logic [1:0] state;
  logic       busy;
  logic       end_pulse;
  logic [7:0] trip_bcd;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  taxi_state_ctrl #(
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD),
    .MAX_WAIT    (MAXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .btn_end   (btn_end),
    .state     (state),
    .busy      (busy),
    .end_pulse (end_pulse),
    .trip_bcd  (trip_bcd)
  );

  // Reference model: trip flags, elapsed/remaining cycle counts, decimal trip count,
  // and per-button raw sample history (index 0 = newest).
  bit m_trip, m_wait, m_endp;
  int m_wait_el, m_hold, m_trips;
  bit m_lvl  [3];
  bit m_pend [3];
  bit m_hist [3][8];

  function automatic void model_reset();
    m_trip = 0; m_wait = 0; m_endp = 0;
    m_wait_el = 0; m_hold = 0; m_trips = 0;
    for (int b = 0; b < 3; b++) begin
      m_lvl[b] = 0;
      m_pend[b] = 0;
      for (int j = 0; j < 8; j++) m_hist[b][j] = 0;
    end
  endfunction

  // A press is seen by the trip logic one edge after its debounced level rises; the
  // debounced level flips once the last DEB samples (two edges old) all disagree with it.
  function automatic void model_step();
    bit raw [3];
    bit timeout, accept, diff;
    int ev;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_pend[2])      ev = 3;
    else if (m_pend[1]) ev = 2;
    else if (m_pend[0]) ev = 1;
    else                ev = 0;
    timeout = m_trip && m_wait && (m_wait_el == MAXW - 1);
    m_endp = 0;
    if (m_trip && (ev == 3 || (timeout && ev == 0))) begin
      m_trip = 0; m_wait = 0; m_endp = 1;
      m_trips = (m_trips + 1) % 100;
      m_hold = HOLD;
    end else if (!m_trip) begin
      accept = (ev == 1) && (m_hold == 0);
      if (m_hold > 0) m_hold--;
      if (accept) begin m_trip = 1; m_wait = 0; end
    end else if (!m_wait) begin
      if (ev == 2) begin m_wait = 1; m_wait_el = 0; end
    end else if (ev == 1 || ev == 2) begin
      m_wait = 0;
    end else begin
      m_wait_el++;
    end
    raw[0] = btn_start; raw[1] = btn_pause; raw[2] = btn_end;
    for (int b = 0; b < 3; b++) begin
      for (int j = 7; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
      m_hist[b][0] = raw[b];
      diff = 1;
      for (int j = 2; j < DEB + 2; j++) if (m_hist[b][j] == m_lvl[b]) diff = 0;
      m_pend[b] = diff && !m_lvl[b];
      if (diff) m_lvl[b] = !m_lvl[b];
    end
  endfunction

  function automatic logic [1:0] m_state();
    return m_trip ? (m_wait ? 2'b11 : 2'b01) : 2'b00;
  endfunction

  function automatic logic [7:0] m_bcd();
    return {4'(m_trips / 10), 4'(m_trips % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    checkOutput("state", 32'(state), 32'(m_state()));
    checkOutput("busy", 32'(busy), 32'(m_trip));
    checkOutput("end_pulse", 32'(end_pulse), 32'(m_endp));
    checkOutput("trip_bcd", 32'(trip_bcd), 32'(m_bcd()));
  endtask

  task automatic drive(input logic [2:0] b, input int n);
    btn_start = b[0]; btn_pause = b[1]; btn_end = b[2];
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [2:0] btns;
    int         press;
    int         idle;
    logic [1:0] exp_state;
    logic [7:0] exp_bcd;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input vec_t v, input int idx);
    drive(v.btns, v.press);
    drive(3'b000, v.idle);
    checkOutput($sformatf("vec%0d state", idx), 32'(state), 32'(v.exp_state));
    checkOutput($sformatf("vec%0d trip", idx), 32'(trip_bcd), 32'(v.exp_bcd));
  endtask

  task automatic doTrip();
    drive(3'b000, 22);
    drive(3'b001, 3);
    drive(3'b000, 6);
    drive(3'b100, 3);
    drive(3'b000, 6);
  endtask

  initial begin
    int n;
    int guard;
    logic [2:0] rb;
    rst = 1'b1;
    btn_start = 1'b0; btn_pause = 1'b0; btn_end = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset state", 32'(state), 32'h0);
    checkOutput("reset trip", 32'(trip_bcd), 32'h0);

    vecs.push_back('{3'b001, 1, 6,  2'b00, 8'h00});
    vecs.push_back('{3'b001, 3, 6,  2'b01, 8'h00});
    vecs.push_back('{3'b001, 3, 6,  2'b01, 8'h00});
    vecs.push_back('{3'b010, 3, 6,  2'b11, 8'h00});
    vecs.push_back('{3'b010, 3, 6,  2'b01, 8'h00});
    vecs.push_back('{3'b010, 3, 6,  2'b11, 8'h00});
    vecs.push_back('{3'b001, 3, 6,  2'b01, 8'h00});
    vecs.push_back('{3'b100, 3, 6,  2'b00, 8'h01});
    vecs.push_back('{3'b100, 3, 25, 2'b00, 8'h01});
    vecs.push_back('{3'b001, 3, 6,  2'b01, 8'h01});
    vecs.push_back('{3'b111, 3, 6,  2'b00, 8'h02});
    vecs.push_back('{3'b010, 3, 6,  2'b00, 8'h02});
    vecs.push_back('{3'b001, 3, 6,  2'b00, 8'h02});
    vecs.push_back('{3'b001, 3, 6,  2'b01, 8'h02});
    vecs.push_back('{3'b100, 3, 11, 2'b00, 8'h03});
    vecs.push_back('{3'b001, 3, 12, 2'b00, 8'h03});
    vecs.push_back('{3'b001, 3, 6,  2'b01, 8'h03});
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Pause into WAIT, then let the wait timer close the trip.
    n = 0;
    for (int i = 0; i < 20; i++) begin
      btn_pause = (i < 3);
      tick();
      n++;
      if (state == 2'b11) break;
    end
    btn_pause = 1'b0;
    checkOutput("enter wait", 32'(state), 32'h3);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (state == 2'b00) break;
    end
    checkOutput("timeout cycles", 32'(n), 32'd50);
    checkOutput("timeout end_pulse", 32'(end_pulse), 32'h1);
    checkOutput("timeout trip", 32'(trip_bcd), 32'h04);

    guard = 0;
    while (m_trips != 99 && guard < 200) begin
      doTrip();
      guard++;
    end
    checkOutput("trip 99", 32'(trip_bcd), 32'h99);
    doTrip();
    checkOutput("trip wrap", 32'(trip_bcd), 32'h00);

    drive(3'b000, 22);
    drive(3'b001, 3);
    drive(3'b000, 6);
    checkOutput("pre-reset move", 32'(state), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid reset state", 32'(state), 32'h0);
    checkOutput("mid reset end_pulse", 32'(end_pulse), 32'h0);
    checkOutput("mid reset trip", 32'(trip_bcd), 32'h00);

    drive(3'b000, 3);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      btn_start = (i < 3);
      tick();
      n++;
      if (state == 2'b01) break;
    end
    btn_start = 1'b0;
    checkOutput("start latency", 32'(n), 32'd5);

    btn_start = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (state == 2'b01) break;
    end
    checkOutput("held through reset", 32'(n), 32'd5);
    drive(3'b000, 8);

    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else if ($urandom_range(0, 14) == 0) begin
        drive(3'b000, 60);
      end else if ($urandom_range(0, 2) == 0) begin
        drive(3'b000, $urandom_range(1, 25));
      end else begin
        rb = 3'($urandom_range(0, 7));
        drive(rb, $urandom_range(1, 6));
      end
    end
    drive(3'b000, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
